// File: rtl/data_mem_responder.sv
// data_mem_responder: shared single-port data RAM serving two cores through
// a req/ack handshake with round-robin arbitration. Each access takes two
// cycles: a grant edge, then a one-cycle ack.
// Optional feature macro: DMEM_STALL_STATS_EN adds per-port contention
// counters (stall_cnt0/stall_cnt1).
module data_mem_responder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              RST,
  input  logic              req0,
  input  logic              write_en0,
  input  logic [ADDR_W-1:0] addr_data_0,
  input  logic [DATA_W-1:0] datain0,
  output logic [DATA_W-1:0] dataout0,
  output logic              ack0,
  input  logic              req1,
  input  logic              write_en1,
  input  logic [ADDR_W-1:0] addr_data_1,
  input  logic [DATA_W-1:0] datain1,
  output logic [DATA_W-1:0] dataout1,
  output logic              ack1
`ifdef DMEM_STALL_STATS_EN
  ,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;   // port that wins when both are pending
  logic              gnt_q;            // port id latched at the grant edge
  logic [DATA_W-1:0] dataout0_q, dataout1_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              pend0, pend1;
  logic              grant, gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;

  // A request is not pending in its own ack cycle, so a held req re-arbitrates.
  assign ack0  = (state_q == ACK) && !gnt_q;
  assign ack1  = (state_q == ACK) &&  gnt_q;
  assign pend0 = req0 && !ack0;
  assign pend1 = req1 && !ack1;

  // Next-state, grant decision and priority update.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant   = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          grant   = 1'b1;
          gnt_id  = (pend0 && pend1) ? prio_q : pend1;
          prio_d  = !gnt_id;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mux the granted port's request onto the single RAM port.
  always_comb begin
    sel_we    = gnt_id ? write_en1   : write_en0;
    sel_addr  = gnt_id ? addr_data_1 : addr_data_0;
    sel_wdata = gnt_id ? datain1     : datain0;
    in_range  = ({1'b0, sel_addr} < DEPTH_L);
    idx       = sel_addr[IDX_W-1:0];
    rd_data   = in_range ? mem[idx] : '0;
  end

  // Control state: FSM, priority pointer and granted port id.
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (grant) gnt_q <= gnt_id;
    end
  end

  // Read data registers: only a read granted to that port updates it.
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      dataout0_q <= '0;
      dataout1_q <= '0;
    end else if (grant && !sel_we) begin
      if (gnt_id) dataout1_q <= rd_data;
      else        dataout0_q <= rd_data;
    end
  end

  assign dataout0 = dataout0_q;
  assign dataout1 = dataout1_q;

  // RAM write port; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge clock) begin
    if (grant && sel_we && in_range && !RST) mem[idx] <= sel_wdata;
  end

`ifdef DMEM_STALL_STATS_EN
  logic [15:0] stall0_q, stall1_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Count IDLE cycles where a port is pending but loses the grant.
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      if (grant && pend0 &&  gnt_id) stall0_q <= sat_inc(stall0_q);
      if (grant && pend1 && !gnt_id) stall1_q <= sat_inc(stall1_q);
    end
  end

  assign stall_cnt0 = stall0_q;
  assign stall_cnt1 = stall1_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder (instantiated with DEPTH=128 so that the
// upper half of the 8-bit address space is out of range).
module tb_data_mem_responder;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              RST;
  logic              req0, write_en0, req1, write_en1;
  logic [ADDR_W-1:0] addr_data_0, addr_data_1;
  logic [DATA_W-1:0] datain0, datain1, dataout0, dataout1;
  logic              ack0, ack1;
`ifdef DMEM_STALL_STATS_EN
  logic [15:0]       stall_cnt0, stall_cnt1;
`endif

  data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .RST(RST),
    .req0(req0), .write_en0(write_en0), .addr_data_0(addr_data_0),
    .datain0(datain0), .dataout0(dataout0), .ack0(ack0),
    .req1(req1), .write_en1(write_en1), .addr_data_1(addr_data_1),
    .datain1(datain1), .dataout1(dataout1), .ack1(ack1)
`ifdef DMEM_STALL_STATS_EN
    , .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] data;
  } sb_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  sb_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] last0 = '0, last1 = '0;
  bit          prev_any = 1'b0;
  bit          last_gnt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every ack pops one expected access.
  always @(negedge clock) begin
    sb_t e;
    if (RST) begin
      prev_any = 1'b0;
    end else begin
      if (ack0 || ack1) begin
        chk("ack_not_back_to_back", {31'd0, prev_any}, 32'd0);
        chk("ack_exclusive", {31'd0, ack0 && ack1}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
          last_gnt = e.port;
          if (!e.we) begin
            if (e.port) last1 = e.data;
            else        last0 = e.data;
          end
          chk("dataout0", {16'd0, dataout0}, {16'd0, last0});
          chk("dataout1", {16'd0, dataout1}, {16'd0, last1});
        end
      end
      prev_any = ack0 || ack1;
    end
  end

  task automatic drive(input bit p, input bit rq, input bit we,
                       input logic [7:0] a, input logic [15:0] d);
    if (p) begin req1 = rq; write_en1 = we; addr_data_1 = a; datain1 = d; end
    else   begin req0 = rq; write_en0 = we; addr_data_0 = a; datain0 = d; end
  endtask

  // Single access from an idle responder; ack must arrive one edge later.
  task automatic access(input bit p, input bit we, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] exp);
    int cyc;
    bit got;
    sb_t e;
    @(posedge clock); #1;
    drive(p, 1'b1, we, a, d);
    e.port = p; e.we = we; e.data = exp;
    sb.push_back(e);
    cyc = 0; got = 0;
    while (!got && cyc < 8) begin
      @(posedge clock); #1;
      cyc++;
      got = p ? ack1 : ack0;
    end
    drive(p, 1'b0, 1'b0, 8'h00, 16'h0000);
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (got) chk("ack_latency", cyc, 32'd1);
  endtask

  vec_t tbl[13];

  initial begin
    int  t0, t1, n, cyc;
    bit  start;
    sb_t e;

    tbl[0]  = '{0, 1, 8'h05, 16'h1234, 16'h0000};
    tbl[1]  = '{0, 0, 8'h05, 16'h0000, 16'h1234};
    tbl[2]  = '{1, 1, 8'h20, 16'hCAFE, 16'h0000};
    tbl[3]  = '{1, 0, 8'h20, 16'h0000, 16'hCAFE};
    tbl[4]  = '{0, 1, 8'h00, 16'h0F0F, 16'h0000};
    tbl[5]  = '{0, 1, 8'h80, 16'hBEEF, 16'h0000};
    tbl[6]  = '{0, 0, 8'h80, 16'h0000, 16'h0000};
    tbl[7]  = '{0, 0, 8'h00, 16'h0000, 16'h0F0F};
    tbl[8]  = '{1, 1, 8'h7F, 16'h7777, 16'h0000};
    tbl[9]  = '{1, 0, 8'h7F, 16'h0000, 16'h7777};
    tbl[10] = '{1, 0, 8'hFF, 16'h0000, 16'h0000};
    tbl[11] = '{1, 1, 8'h05, 16'hABCD, 16'h0000};
    tbl[12] = '{0, 0, 8'h05, 16'h0000, 16'hABCD};

    RST = 1'b1;
    drive(0, 0, 0, 8'h00, 16'h0000);
    drive(1, 0, 0, 8'h00, 16'h0000);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_dataout0", {16'd0, dataout0}, 32'd0);
    chk("rst_dataout1", {16'd0, dataout1}, 32'd0);
`ifdef DMEM_STALL_STATS_EN
    chk("rst_stall0", {16'd0, stall_cnt0}, 32'd0);
    chk("rst_stall1", {16'd0, stall_cnt1}, 32'd0);
`endif
    RST = 1'b0;

    // Simultaneous writes right after reset: core0 wins, core1 two cycles later.
    @(posedge clock); #1;
    drive(0, 1, 1, 8'h10, 16'hAAAA);
    drive(1, 1, 1, 8'h10, 16'h5555);
    e = '{0, 1, 16'h0}; sb.push_back(e);
    e = '{1, 1, 16'h0}; sb.push_back(e);
    t0 = -1; t1 = -1; cyc = 0;
    while ((t0 < 0 || t1 < 0) && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
      if (ack0) begin t0 = cyc; drive(0, 0, 0, 8'h00, 16'h0000); end
      if (ack1) begin t1 = cyc; drive(1, 0, 0, 8'h00, 16'h0000); end
    end
    drive(0, 0, 0, 8'h00, 16'h0000);
    drive(1, 0, 0, 8'h00, 16'h0000);
    chk("simul_ack0_cycle", t0, 32'd1);
    chk("simul_ack1_cycle", t1, 32'd3);
    access(0, 0, 8'h10, 16'h0000, 16'h5555);

    // Table of single accesses, including out-of-range addresses.
    for (int i = 0; i < 13; i++)
      access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Round robin: both cores hold reads for 8 grants.
    @(posedge clock); #1;
    start = !last_gnt;
    for (int i = 0; i < 8; i++) begin
      e.port = start ^ i[0];
      e.we   = 1'b0;
      e.data = e.port ? 16'hCAFE : 16'hABCD;
      sb.push_back(e);
    end
    drive(0, 1, 0, 8'h05, 16'h0000);
    drive(1, 1, 0, 8'h20, 16'h0000);
    n = 0; cyc = 0;
    while (n < 8 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (ack0 || ack1) n++;
    end
    drive(0, 0, 0, 8'h00, 16'h0000);
    drive(1, 0, 0, 8'h00, 16'h0000);
    chk("rr_grants", n, 32'd8);
    chk("rr_cycles", cyc, 32'd15);
    repeat (3) @(posedge clock);
    #1;
    chk("rr_sb_drained", sb.size(), 32'd0);
`ifdef DMEM_STALL_STATS_EN
    chk("stall0_ge3", {31'd0, stall_cnt0 >= 16'd3}, 32'd1);
    chk("stall1_ge3", {31'd0, stall_cnt1 >= 16'd3}, 32'd1);
`endif

    // Held request: req0 stays high across its ack for two accesses.
    e = '{0, 0, 16'h0F0F}; sb.push_back(e); sb.push_back(e);
    drive(0, 1, 0, 8'h00, 16'h0000);
    t0 = -1; t1 = -1; cyc = 0;
    while (t1 < 0 && cyc < 12) begin
      @(posedge clock); #1;
      cyc++;
      if (ack0) begin
        if (t0 < 0) t0 = cyc;
        else begin t1 = cyc; drive(0, 0, 0, 8'h00, 16'h0000); end
      end
    end
    drive(0, 0, 0, 8'h00, 16'h0000);
    chk("held_first_ack", t0, 32'd1);
    chk("held_second_ack", t1, 32'd3);
    repeat (3) @(posedge clock);
    #1;
    chk("held_sb_drained", sb.size(), 32'd0);

    // Reset in the ACK cycle of a core1 read.
    drive(1, 1, 0, 8'h20, 16'h0000);
    @(posedge clock); #1;
    chk("mid_ack1_high", {31'd0, ack1}, 32'd1);
    chk("mid_dataout1_read", {16'd0, dataout1}, 32'h0000CAFE);
    RST = 1'b1;
    #1;
    chk("mid_rst_ack1", {31'd0, ack1}, 32'd0);
    chk("mid_rst_dataout1", {16'd0, dataout1}, 32'd0);
    chk("mid_rst_dataout0", {16'd0, dataout0}, 32'd0);
    sb.delete();
    last0 = '0; last1 = '0;
    drive(1, 0, 0, 8'h00, 16'h0000);
    repeat (2) @(posedge clock);
    #1;
    RST = 1'b0;
    access(0, 0, 8'h05, 16'h0000, 16'hABCD);
    access(1, 0, 8'h10, 16'h0000, 16'h5555);

    repeat (3) @(posedge clock);
    #1;
    chk("final_sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
